// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read port to valid/ready stream adapter with a 3-entry output buffer
// Optional word counter port is enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic                  inflight;
  logic [1:0]            occ, rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] mem [3];
  logic                  flush_start, push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read credit counts the in-flight word so the buffer can never overflow.
  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    flush_start = flush && (state != FLUSH);
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        fifo_rd_en = !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
        if (!en) state_nxt = IDLE;
      end
      FLUSH: begin
        fifo_rd_en = !fifo_empty;
        if (fifo_empty && !inflight) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_start) state_nxt = FLUSH;
  end

  assign push    = inflight && (state != FLUSH) && !flush_start;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign busy    = (state != IDLE) || (occ != 2'd0) || inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
      occ      <= 2'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en && !fifo_empty;
      if (flush_start) begin
        occ    <= 2'd0;
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= fifo_data;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst) !(push && (occ == 2'd3)));

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (flush_start) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed and randomized bench for fifo_rd_stream against a queue-based reference
module tb_fifo_rd_stream;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en, m_valid, busy;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]   word_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    int            rdy;
  } ent_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            mode = 0;       // 0 idle, 1 fetching, 2 draining
  logic          last_acc = 1'b0;
  logic [15:0]   cnt_m = '0;
  logic [DW-1:0] fq [$];         // FIFO contents
  ent_t          exp_q [$];      // words read from the FIFO, not yet delivered
  logic          obs_acc, obs_hs, obs_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mode     = 0;
    last_acc = 1'b0;
    cnt_m    = '0;
  endtask

  // Entered and left at posedge+2; observes at posedge+4.
  task automatic cycle();
    ent_t e;
    logic exp_v, exp_rd, entering;
    #2;
    exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    chk("m_valid", 32'(m_valid), 32'(exp_v));
    if (exp_v) chk("m_data", 32'(m_data), 32'(exp_q[0].d));
    exp_rd = !fifo_empty && (((mode == 1) && (exp_q.size() < 3)) || (mode == 2));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    chk("busy", 32'(busy), 32'((mode != 0) || (exp_q.size() != 0)));
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("word_cnt", 32'(word_cnt), 32'(cnt_m));
`endif
    obs_valid = m_valid;
    obs_acc   = fifo_rd_en && !fifo_empty;
    obs_hs    = m_valid && m_ready;
    entering  = flush && (mode != 2);
    if (obs_hs && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      cnt_m++;
    end
    if (obs_acc && !entering && mode != 2) begin
      e.d   = fq[0];
      e.rdy = cyc + 2;
      exp_q.push_back(e);
    end
    if (entering) begin
      exp_q.delete();
      cnt_m = '0;
      mode  = 2;
    end else if (mode == 2) begin
      if (fifo_empty && !last_acc) mode = 0;
    end else begin
      mode = en ? 1 : 0;
    end
    last_acc = obs_acc;
    @(posedge clk);
    #1;
    if (obs_acc) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, v_cyc, n, nhs, first_hs, last_hs;
    logic [DW-1:0] w0;
    logic found;

    // reset values
    #3;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();

    // 1: running with an empty FIFO, then asynchronous reset mid-run
    en = 1'b1;
    m_ready = 1'b1;
    repeat (4) cycle();
    chk("t1_busy_run", 32'(busy), 32'd1);
    chk("t1_no_read", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_valid", 32'(m_valid), 32'd0);
    chk("t1_async_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t1_async_data", 32'(m_data), 32'd0);
    en = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    cyc++;

    // 2: single word latency
    push_word(16'hA5A5);
    en = 1'b1;
    a_cyc = -100;
    v_cyc = -1000;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_acc) begin
        a_cyc = cyc - 1;
        n++;
      end
      if (obs_valid && v_cyc < 0) v_cyc = cyc - 1;
    end
    chk("t2_reads", 32'(n), 32'd1);
    chk("t2_latency", 32'(v_cyc - a_cyc), 32'd2);

    // 3: 64-word stream at full rate
    for (int i = 0; i < 64; i++) push_word(DW'(i));
    nhs = 0;
    first_hs = -1;
    last_hs = -1;
    for (int i = 0; i < 200 && nhs < 64; i++) begin
      cycle();
      if (obs_hs) begin
        if (first_hs < 0) first_hs = cyc - 1;
        last_hs = cyc - 1;
        nhs++;
      end
    end
    chk("t3_count", 32'(nhs), 32'd64);
    chk("t3_contiguous", 32'(last_hs - first_hs), 32'd63);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("t3_word_cnt", 32'(word_cnt), 32'd65);
`endif

    // 4: backpressure
    m_ready = 1'b0;
    w0 = DW'($urandom);
    push_word(w0);
    for (int i = 0; i < 9; i++) push_word(DW'($urandom));
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_acc) n++;
    end
    chk("t4_reads", 32'(n), 32'd3);
    chk("t4_hold_valid", 32'(m_valid), 32'd1);
    chk("t4_hold_data", 32'(m_data), 32'(w0));
    m_ready = 1'b1;
    nhs = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_hs) nhs++;
    end
    chk("t4_delivered", 32'(nhs), 32'd10);

    // 5: flush with buffered and in-flight words
    m_ready = 1'b0;
    for (int i = 0; i < 24; i++) push_word(DW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = (exp_q.size() == 3) && last_acc;
    end
    chk("t5_setup", 32'(found), 32'd1);
    en = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t5_valid_drop", 32'(m_valid), 32'd0);
    for (int i = 0; i < 60 && busy; i++) cycle();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_fifo_drained", 32'(fq.size()), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("t5_word_cnt", 32'(word_cnt), 32'd0);
`endif

    // 6: en drops in the cycle of an accepted read
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(DW'($urandom));
    en = 1'b1;
    for (int i = 0; i < 10 && !fifo_rd_en; i++) cycle();
    chk("t6_read_seen", 32'(fifo_rd_en), 32'd1);
    en = 1'b0;
    cycle();
    n = 0;
    nhs = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_acc) n++;
      if (obs_hs) nhs++;
    end
    chk("t6_no_reads", 32'(n), 32'd0);
    chk("t6_landed", 32'(nhs), 32'd1);
    en = 1'b1;
    nhs = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_hs) nhs++;
    end
    chk("t6_rest", 32'(nhs), 32'd5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom % 8) != 0;
      m_ready = ($urandom % 3) != 0;
      flush   = ($urandom % 60) == 0;
      if (($urandom % 4) == 0 && fq.size() < 64) push_word(DW'($urandom));
      cycle();
      flush = 1'b0;
    end
    en = 1'b1;
    m_ready = 1'b1;
    repeat (150) cycle();
    en = 1'b0;
    repeat (5) cycle();
    chk("final_fifo_empty", 32'(fq.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
